// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU serial frame generator.
//   alu_op_t      ALU opcodes carried in the CMD frame
//   OP_UNKNOWN    opcode the DUT must reject, used for error injection
//   frame_mode_t  packet error-injection mode
//   gen_state_t   frame generator FSM states
//   FRAME_BITS    serial bits per frame (start, type, 8 payload, stop)
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } alu_op_t;

  localparam logic [2:0] OP_UNKNOWN = 3'b010;

  typedef enum logic [1:0] {
    MODE_GOOD     = 2'b00,
    MODE_BAD_CRC  = 2'b01,
    MODE_BAD_DATA = 2'b10,
    MODE_BAD_OP   = 2'b11
  } frame_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_CMD  = 2'b10,
    ST_GAP  = 2'b11
  } gen_state_t;

  localparam int FRAME_BITS = 11;

endpackage

// File: rtl/alu_crc4.sv
// alu_crc4: combinational CRC4, crc = (M(x) * x^4) mod (x^4 + x + 1), init 0.
// M is consumed MSB first.
//   m    in   W  message vector
//   crc  out  4  remainder
module alu_crc4 #(
  parameter int W = 68
) (
  input  logic [W-1:0] m,
  output logic [3:0]   crc
);

  // Serial LFSR form of the division, unrolled over all W message bits.
  always_comb begin
    logic fb;
    crc = 4'h0;
    fb  = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      fb  = crc[3] ^ m[i];
      crc = {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
  end

endmodule

// File: rtl/alu_frame_gen.sv
// alu_frame_gen: serial frame generator for the ALU sin protocol. Accepts one
// operand/opcode request per handshake and sends B bytes, A bytes, then a CMD
// frame carrying opcode and CRC4, followed by an idle gap. Supports error
// injection (bad CRC, missing data frame, unknown opcode).
// Optional build macro: ALU_FRAME_GEN_STATS_EN adds pkt_cnt/err_cnt.
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous active-high reset
//   req_valid  in   1       request present
//   req_ready  out  1       idle, request taken on valid&&ready
//   req_a      in   DATA_W  operand A
//   req_b      in   DATA_W  operand B
//   req_op     in   3       opcode (alu_op_t)
//   req_mode   in   2       frame_mode_t
//   sin        out  1       serial line, idle high
//   busy       out  1       packet or gap in progress
//   done       out  1       one-cycle pulse on the last gap cycle
//   pkt_cnt    out  16      packets sent (stats build only)
//   err_cnt    out  16      packets sent with mode != GOOD (stats build only)
//
// state   | meaning
// IDLE    | waiting for request, sin=1, req_ready=1
// DATA    | shifting data frames (B bytes then A bytes)
// CMD     | shifting the command frame {0, op, crc}
// GAP     | sin=1 for IDLE_GAP bit periods, done on last cycle
module alu_frame_gen
  import alu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int BIT_DIV  = 1,
  parameter int IDLE_GAP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [2:0]        req_op,
  input  logic [1:0]        req_mode,
  output logic              sin,
  output logic              busy,
  output logic              done
`ifdef ALU_FRAME_GEN_STATS_EN
  ,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       err_cnt
`endif
);

  localparam int BYTES   = DATA_W / 8;
  localparam int NFRM    = 2 * BYTES;
  localparam int FCW     = $clog2(NFRM + 1);
  localparam int DIVW    = $clog2(BIT_DIV + 1);
  localparam int GAP_CYC = IDLE_GAP * BIT_DIV;
  localparam int GAPW    = $clog2(GAP_CYC + 1);
  localparam int CRC_W   = 2 * DATA_W + 4;

  localparam logic [FCW-1:0]  N_FULL   = FCW'(NFRM);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BIT_DIV - 1);
  localparam logic [3:0]      BIT_LAST = 4'(FRAME_BITS - 1);
  localparam logic [GAPW-1:0] GAP_LOAD = GAPW'(GAP_CYC - 1);

  gen_state_t          state_q, state_d;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [2:0]          op_q;
  frame_mode_t         mode_q;
  logic [FCW-1:0]      frame_cnt;
  logic [3:0]          bit_cnt;
  logic [DIVW-1:0]     div_cnt;
  logic [GAPW-1:0]     gap_cnt;

  logic                accept;
  logic                bit_end;
  logic                frame_end;
  logic                last_data;
  logic                gap_end;
  logic [FCW-1:0]      n_data;
  logic [3:0]          crc_calc;
  logic [3:0]          crc_tx;
  logic [2:0]          op_tx;
  logic [2*DATA_W-1:0] data_vec;
  logic [7:0]          payload;
  logic [FRAME_BITS-1:0] frame_word;

  alu_crc4 #(
    .W (CRC_W)
  ) u_crc (
    .m   ({b_q, a_q, 1'b1, op_q}),
    .crc (crc_calc)
  );

  assign accept    = req_valid && (state_q == ST_IDLE);
  assign bit_end   = (div_cnt == DIV_LAST);
  assign frame_end = bit_end && (bit_cnt == BIT_LAST);
  // BAD_DATA drops the last A byte, i.e. the final data frame.
  assign n_data    = (mode_q == MODE_BAD_DATA) ? (N_FULL - FCW'(1)) : N_FULL;
  assign last_data = (frame_cnt == (n_data - FCW'(1)));
  // gap_cnt is a down-counter; terminal count marks the last gap cycle.
  assign gap_end   = (gap_cnt == '0);

  assign op_tx     = (mode_q == MODE_BAD_OP) ? OP_UNKNOWN : op_q;
  assign crc_tx    = ((mode_q == MODE_BAD_CRC) || (mode_q == MODE_BAD_DATA)) ?
                     (crc_calc + 4'd1) : crc_calc;
  assign data_vec  = {b_q, a_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (frame_end && last_data) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (frame_end) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_end) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      mode_q    <= MODE_GOOD;
      frame_cnt <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q       <= req_a;
            b_q       <= req_b;
            op_q      <= req_op;
            mode_q    <= frame_mode_t'(req_mode);
            frame_cnt <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
          end
        end
        ST_DATA, ST_CMD: begin
          div_cnt <= bit_end ? '0 : (div_cnt + DIVW'(1));
          if (bit_end) begin
            bit_cnt <= (bit_cnt == BIT_LAST) ? 4'd0 : (bit_cnt + 4'd1);
          end
          if (frame_end) begin
            if (state_q == ST_DATA) frame_cnt <= frame_cnt + FCW'(1);
            else                    gap_cnt   <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (!gap_end) gap_cnt <= gap_cnt - GAPW'(1);
        end
        default: ;
      endcase
    end
  end

  // Frames are sent MSB first: start 0, type, payload[7:0], stop 1.
  always_comb begin
    int byte_idx;
    byte_idx = 0;
    if (state_q == ST_DATA) byte_idx = NFRM - 1 - int'(frame_cnt);
    if (state_q == ST_CMD) payload = {1'b0, op_tx, crc_tx};
    else                   payload = data_vec[byte_idx*8 +: 8];
    frame_word = {1'b0, (state_q == ST_CMD), payload, 1'b1};
    if ((state_q == ST_DATA) || (state_q == ST_CMD)) sin = frame_word[BIT_LAST - bit_cnt];
    else                                             sin = 1'b1;
  end

`ifdef ALU_FRAME_GEN_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else if (done) begin
      pkt_cnt <= pkt_cnt + 16'd1;
      if (mode_q != MODE_GOOD) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_frame_gen.sv
module tb_alu_frame_gen;
  import alu_pkg::*;

  localparam int DW0 = 32, BD0 = 1, GP0 = 16;
  localparam int DW1 = 16, BD1 = 3, GP1 = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [31:0] req_a, req_b;
  logic [2:0]  req_op;
  logic [1:0]  req_mode;
  logic        ready0, sin0, busy0, done0;
  logic        ready1, sin1, busy1, done1;
`ifdef ALU_FRAME_GEN_STATS_EN
  logic [15:0] pkt0, err0, pkt1, err1;
`endif

  always #5 clk = ~clk;

  alu_frame_gen #(.DATA_W(DW0), .BIT_DIV(BD0), .IDLE_GAP(GP0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid[0]),
    .req_ready (ready0),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .req_mode  (req_mode),
    .sin       (sin0),
    .busy      (busy0),
    .done      (done0)
`ifdef ALU_FRAME_GEN_STATS_EN
    ,
    .pkt_cnt   (pkt0),
    .err_cnt   (err0)
`endif
  );

  alu_frame_gen #(.DATA_W(DW1), .BIT_DIV(BD1), .IDLE_GAP(GP1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid[1]),
    .req_ready (ready1),
    .req_a     (req_a[15:0]),
    .req_b     (req_b[15:0]),
    .req_op    (req_op),
    .req_mode  (req_mode),
    .sin       (sin1),
    .busy      (busy1),
    .done      (done1)
`ifdef ALU_FRAME_GEN_STATS_EN
    ,
    .pkt_cnt   (pkt1),
    .err_cnt   (err1)
`endif
  );

  logic cur;
  wire  rdy_m  = cur ? ready1 : ready0;
  wire  sin_m  = cur ? sin1   : sin0;
  wire  busy_m = cur ? busy1  : busy0;
  wire  done_m = cur ? done1  : done0;
`ifdef ALU_FRAME_GEN_STATS_EN
  wire [15:0] pkt_m = cur ? pkt1 : pkt0;
  wire [15:0] err_m = cur ? err1 : err0;
`endif

  int total_cnt = 0;
  int bad_cnt   = 0;
  int mdl_pkt[2];
  int mdl_err[2];
  logic exp_bits[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Textbook polynomial long division of M*x^4 by x^4+x+1 (0x13).
  function automatic logic [3:0] ref_crc(input int dw, input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    logic [79:0] v;
    int nbits;
    v = '0;
    v = 80'(b);
    v = (v << dw) | 80'(a);
    v = (v << 4) | 80'({1'b1, op});
    v = v << 4;
    nbits = 2 * dw + 8;
    for (int i = nbits - 1; i >= 4; i--)
      if (v[i]) v = v ^ (80'h13 << (i - 4));
    return v[3:0];
  endfunction

  task automatic push_frame(input logic typ, input logic [7:0] pl);
    exp_bits.push_back(1'b0);
    exp_bits.push_back(typ);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(pl[i]);
    exp_bits.push_back(1'b1);
  endtask

  task automatic build(input int dw, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [1:0] mode);
    int bytes, ndata;
    logic [3:0] crc, crc_tx;
    logic [2:0] op_tx;
    bytes = dw / 8;
    crc   = ref_crc(dw, a, b, op);
    ndata = (mode == 2'b10) ? 2 * bytes - 1 : 2 * bytes;
    exp_bits.delete();
    for (int k = 0; k < ndata; k++) begin
      if (k < bytes) push_frame(1'b0, 8'(b >> (8 * (bytes - 1 - k))));
      else           push_frame(1'b0, 8'(a >> (8 * (2 * bytes - 1 - k))));
    end
    op_tx  = (mode == 2'b11) ? 3'b010 : op;
    crc_tx = (mode == 2'b01 || mode == 2'b10) ? crc + 4'd1 : crc;
    push_frame(1'b1, {1'b0, op_tx, crc_tx});
  endtask

  // Called and returns at a falling edge.
  task automatic run_pkt(input int sel, input logic [31:0] a_in, input logic [31:0] b_in,
                         input logic [2:0] op, input logic [1:0] mode, input bit hold,
                         input int abort_at, input int exp_wait);
    int dw, bd, gp, nbits, total, waits, sin_err, hs_err, done_cyc, n_done;
    logic [31:0] a, b;
    logic exp_s;
    dw = sel ? DW1 : DW0;
    bd = sel ? BD1 : BD0;
    gp = sel ? GP1 : GP0;
    a  = (dw == 16) ? (a_in & 32'hFFFF) : a_in;
    b  = (dw == 16) ? (b_in & 32'hFFFF) : b_in;
    build(dw, a, b, op, mode);
    nbits = exp_bits.size();
    total = nbits * bd + gp * bd;
    cur = sel[0];
    req_a = a_in; req_b = b_in; req_op = op; req_mode = mode;
    req_valid[sel] = 1'b1;
    #1;
    waits = 0;
    while (!rdy_m && waits < 1000) begin
      @(negedge clk);
      waits++;
    end
    if (!rdy_m) begin
      check("accept_timeout", 64'(rdy_m), 64'd1);
      req_valid[sel] = 1'b0;
      return;
    end
    if (exp_wait >= 0) check("accept_wait", 64'(waits), 64'(exp_wait));
    @(posedge clk);
    sin_err = 0; hs_err = 0; done_cyc = -1; n_done = 0;
    for (int cyc = 1; cyc <= total + 1; cyc++) begin
      @(negedge clk);
      if (!hold) req_valid[sel] = 1'b0;
      if (cyc == abort_at) begin
        req_valid = '0;
        rst = 1'b1;
        #1;
        check("rst_sin", 64'(sin_m), 64'd1);
        check("rst_ready", 64'(rdy_m), 64'd1);
        check("rst_busy", 64'(busy_m), 64'd0);
        check("rst_done", 64'(done_m), 64'd0);
        mdl_pkt[0] = 0; mdl_pkt[1] = 0; mdl_err[0] = 0; mdl_err[1] = 0;
`ifdef ALU_FRAME_GEN_STATS_EN
        check("rst_pkt_cnt", 64'(pkt_m), 64'd0);
        check("rst_err_cnt", 64'(err_m), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (cyc <= total) begin
        exp_s = (cyc <= nbits * bd) ? exp_bits[(cyc - 1) / bd] : 1'b1;
        if (sin_m !== exp_s) sin_err++;
        if (busy_m !== 1'b1 || rdy_m !== 1'b0) hs_err++;
        if (done_m === 1'b1) begin
          n_done++;
          if (done_cyc < 0) done_cyc = cyc;
        end
      end else begin
        check("idle_ready", 64'(rdy_m), 64'd1);
        check("idle_busy", 64'(busy_m), 64'd0);
        check("idle_sin", 64'(sin_m), 64'd1);
        check("idle_done", 64'(done_m), 64'd0);
      end
    end
    check("sin_stream_errs", 64'(sin_err), 64'd0);
    check("busy_ready_errs", 64'(hs_err), 64'd0);
    check("done_cycle", 64'(done_cyc), 64'(total));
    check("done_pulses", 64'(n_done), 64'd1);
    mdl_pkt[sel] = (mdl_pkt[sel] + 1) % 65536;
    if (mode != 2'b00) mdl_err[sel] = (mdl_err[sel] + 1) % 65536;
`ifdef ALU_FRAME_GEN_STATS_EN
    check("pkt_cnt", 64'(pkt_m), 64'(mdl_pkt[sel]));
    check("err_cnt", 64'(err_m), 64'(mdl_err[sel]));
`endif
  endtask

  function automatic logic [2:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b100;
      default: return 3'b101;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0; req_b = '0; req_op = '0; req_mode = '0;
    cur = 1'b0;
    mdl_pkt[0] = 0; mdl_pkt[1] = 0; mdl_err[0] = 0; mdl_err[1] = 0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(ready0), 64'd1);
    check("reset_sin", 64'(sin0), 64'd1);
    check("reset_busy", 64'(busy0), 64'd0);
    check("reset_done", 64'(done0), 64'd0);
    check("reset_sin_div3", 64'(sin1), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Directed: all four modes with A=B=0, opcode AND.
    for (int m = 0; m < 4; m++) run_pkt(0, 32'h0, 32'h0, OP_AND, 2'(m), 1'b0, -1, 0);

    // Valid held across two requests: second must be taken right after done.
    run_pkt(0, 32'h1234_5678, 32'h9ABC_DEF0, OP_ADD, 2'b00, 1'b1, -1, -1);
    run_pkt(0, 32'hCAFE_F00D, 32'h0BAD_BEEF, OP_SUB, 2'b01, 1'b0, -1, 0);

    // Reset in the middle of a GOOD packet, then recovery.
    run_pkt(0, 32'hFFFF_FFFF, 32'h8000_0001, OP_OR, 2'b00, 1'b0, 40, -1);
    run_pkt(0, 32'h0000_00A5, 32'h5A00_0000, OP_AND, 2'b11, 1'b0, -1, 0);

    for (int i = 0; i < 8; i++)
      run_pkt(0, $urandom, $urandom, rand_op(), 2'($urandom_range(0, 3)), 1'b0, -1, -1);

    // Second instance: DATA_W=16, BIT_DIV=3.
    run_pkt(1, 32'h0, 32'h0, OP_AND, 2'b00, 1'b0, -1, 0);
    run_pkt(1, 32'h0000_1357, 32'h0000_2468, OP_ADD, 2'b10, 1'b1, -1, -1);
    run_pkt(1, 32'h0000_ABCD, 32'h0000_0F0F, OP_SUB, 2'b00, 1'b0, -1, 0);
    for (int i = 0; i < 3; i++)
      run_pkt(1, $urandom, $urandom, rand_op(), 2'($urandom_range(0, 3)), 1'b0, -1, -1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
